// File: rtl/quant_pkg.sv
// -----------------------------------------------------------------------------
// quant_pkg
// Shared constants for the quantizer stage and its sequencer (quant_ctrl):
//   ROWS_PER_BLOCK_DEF : default rows per block
//   QUANT_LANES        : lanes per row
//   QUANT_IN_W         : quantizer input sample width
//   QUANT_OUT_W        : quantizer rounded output width
//   state_e            : sequencer state encoding (IDLE, RUN)
// -----------------------------------------------------------------------------
package quant_pkg;

    localparam int ROWS_PER_BLOCK_DEF = 8;
    localparam int QUANT_LANES        = 8;
    localparam int QUANT_IN_W         = 9;
    localparam int QUANT_OUT_W        = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : quant_pkg

// File: rtl/quant_ctrl_if.sv
// -----------------------------------------------------------------------------
// quant_ctrl_if
// Row stream between the transform stage, the sequencer and the quantizer.
//   in_valid / in_ready   : upstream row handshake
//   out_ready             : downstream credit (high at t => out_valid at t+1 taken)
//   enable_output         : quantizer enable, same cycle as row data at its inputs
//   out_valid, out_row,
//   out_last_row,
//   block_done, frame_done: markers aligned with the quantizer registered outputs
// Modports: slave = sequencer side, master = upstream/downstream side.
// ROWS_PER_BLOCK must match the value given to quant_ctrl.
// -----------------------------------------------------------------------------
interface quant_ctrl_if
    import quant_pkg::*;
#(
    parameter int ROWS_PER_BLOCK = ROWS_PER_BLOCK_DEF
) ();

    localparam int ROW_W = $clog2(ROWS_PER_BLOCK);

    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             enable_output;
    logic             out_valid;
    logic [ROW_W-1:0] out_row;
    logic             out_last_row;
    logic             block_done;
    logic             frame_done;

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output enable_output,
        output out_valid,
        output out_row,
        output out_last_row,
        output block_done,
        output frame_done
    );

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  enable_output,
        input  out_valid,
        input  out_row,
        input  out_last_row,
        input  block_done,
        input  frame_done
    );

endinterface : quant_ctrl_if

// File: rtl/quant_ctrl.sv
// -----------------------------------------------------------------------------
// quant_ctrl
// Sequencer for the 8-lane quantizer. Accepts rows from the transform stage,
// drives the quantizer enable, counts rows per block and blocks per frame, and
// emits row/block/frame markers one cycle after acceptance so they line up with
// the quantizer's registered outputs.
// Ports:
//   clk, nrst   : clock (rising edge), asynchronous active-low reset
//   start       : frame start pulse, sampled only in IDLE
//   abort       : synchronous frame abort
//   num_blocks  : blocks in frame, latched on accepted start
//   row_if      : row stream (quant_ctrl_if.slave)
//   blk_idx     : index of block currently being accepted
//   busy        : RUN state or an output row still in flight
//   stall_cnt   : (QUANT_CTRL_STALL_CNT_EN only) RUN cycles with in_valid but
//                 no downstream credit; clears on accepted start, saturates
// Optional feature macro: QUANT_CTRL_STALL_CNT_EN
// -----------------------------------------------------------------------------
module quant_ctrl
    import quant_pkg::*;
#(
    parameter int ROWS_PER_BLOCK = ROWS_PER_BLOCK_DEF,
    parameter int BLK_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BLK_CNT_W-1:0] num_blocks,
    quant_ctrl_if.slave          row_if,
    output logic [BLK_CNT_W-1:0] blk_idx,
    output logic                 busy
`ifdef QUANT_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int               ROW_W    = $clog2(ROWS_PER_BLOCK);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS_PER_BLOCK - 1);

    state_e               state_q, state_d;
    logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
    logic [BLK_CNT_W-1:0] blk_idx_q, blk_idx_d;
    logic [BLK_CNT_W-1:0] num_blocks_q, num_blocks_d;
    logic                 out_valid_q, out_valid_d;
    logic [ROW_W-1:0]     out_row_q, out_row_d;
    logic                 out_last_q, out_last_d;
    logic                 frame_done_q, frame_done_d;
`ifdef QUANT_CTRL_STALL_CNT_EN
    logic [31:0]          stall_cnt_q, stall_cnt_d;
`endif

    logic in_ready;
    logic accept;
    logic last_row;
    logic last_blk;

    assign in_ready = (state_q == RUN) && row_if.out_ready && !abort;
    assign accept   = row_if.in_valid && in_ready;
    assign last_row = (row_cnt_q == LAST_ROW);
    assign last_blk = (blk_idx_q == (num_blocks_q - BLK_CNT_W'(1)));

    // NOTE: every signal assigned below gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        blk_idx_d    = blk_idx_q;
        num_blocks_d = num_blocks_q;
        // Markers describe the row accepted this cycle; all zero otherwise.
        out_valid_d  = accept;
        out_row_d    = accept ? row_cnt_q : '0;
        out_last_d   = accept && last_row;
        frame_done_d = accept && last_row && last_blk;
`ifdef QUANT_CTRL_STALL_CNT_EN
        stall_cnt_d  = stall_cnt_q;
        if ((state_q == RUN) && row_if.in_valid && !row_if.out_ready &&
            (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
`endif

        unique case (state_q)
            IDLE: begin
                // start beats abort here; abort has no meaning outside RUN.
                if (start) begin
                    if (num_blocks != '0) begin
                        state_d      = RUN;
                        num_blocks_d = num_blocks;
                        row_cnt_d    = '0;
                        blk_idx_d    = '0;
`ifdef QUANT_CTRL_STALL_CNT_EN
                        stall_cnt_d  = '0;
`endif
                    end else begin
                        // Empty frame completes immediately.
                        frame_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = IDLE;
                    row_cnt_d = '0;
                    blk_idx_d = '0;
                end else if (accept) begin
                    if (last_row) begin
                        row_cnt_d = '0;
                        if (last_blk) begin
                            state_d   = IDLE;
                            blk_idx_d = '0;
                        end else begin
                            blk_idx_d = blk_idx_q + BLK_CNT_W'(1);
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            row_cnt_q    <= '0;
            blk_idx_q    <= '0;
            num_blocks_q <= '0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef QUANT_CTRL_STALL_CNT_EN
            stall_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            blk_idx_q    <= blk_idx_d;
            num_blocks_q <= num_blocks_d;
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
`ifdef QUANT_CTRL_STALL_CNT_EN
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    assign row_if.in_ready      = in_ready;
    assign row_if.enable_output = accept;
    assign row_if.out_valid     = out_valid_q;
    assign row_if.out_row       = out_row_q;
    assign row_if.out_last_row  = out_last_q;
    // A block ends exactly on its last row, so both markers share one flop.
    assign row_if.block_done    = out_last_q;
    assign row_if.frame_done    = frame_done_q;
    assign blk_idx              = blk_idx_q;
    assign busy                 = (state_q == RUN) || out_valid_q;
`ifdef QUANT_CTRL_STALL_CNT_EN
    assign stall_cnt            = stall_cnt_q;
`endif

endmodule : quant_ctrl

// File: tb/tb_quant_ctrl.sv
// -----------------------------------------------------------------------------
// tb_quant_ctrl
// Self-checking bench for quant_ctrl. A reference model tracks a frame as a
// plain count of accepted rows (row = n % R, block = n / R, frame ends at
// n == blocks * R) and predicts every output each cycle. Scenario tasks add
// their own checks on pulse counts, row sequences and timing.
// Honours QUANT_CTRL_STALL_CNT_EN.
// -----------------------------------------------------------------------------
module tb_quant_ctrl;
    import quant_pkg::*;

    localparam int R     = 8;
    localparam int BW    = 16;
    localparam int ROW_W = $clog2(R);

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [BW-1:0] num_blocks = '0;
    logic [BW-1:0] blk_idx;
    logic          busy;
`ifdef QUANT_CTRL_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    quant_ctrl_if #(.ROWS_PER_BLOCK(R)) row_if ();

    quant_ctrl #(.ROWS_PER_BLOCK(R), .BLK_CNT_W(BW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .abort      (abort),
        .num_blocks (num_blocks),
        .row_if     (row_if),
        .blk_idx    (blk_idx),
        .busy       (busy)
`ifdef QUANT_CTRL_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit     m_run;
    int     m_rows;
    int     m_nblk;
    bit     m_ov, m_olast, m_fd;
    int     m_orow;
    longint m_stall;

    // DUT values observed at the last tick
    bit o_ir, o_en, o_ov, o_bd, o_fd, o_busy;
    int o_row, o_blk;
    int obs_rows[$];

    task automatic model_reset();
        m_run = 0; m_rows = 0; m_nblk = 0;
        m_ov = 0; m_olast = 0; m_fd = 0; m_orow = 0; m_stall = 0;
    endtask

    // One clock cycle: inputs are already set (driven just after posedge).
    // Compare DUT to the model at negedge, then advance the model at posedge.
    task automatic tick();
        bit e_ir, e_acc, e_busy, n_ov, n_last, n_fd;
        int e_blk, n_row;
        @(negedge clk);
        e_ir   = m_run && row_if.out_ready && !abort;
        e_acc  = e_ir && row_if.in_valid;
        e_blk  = m_run ? (m_rows / R) : 0;
        e_busy = m_run || m_ov;

        o_ir = row_if.in_ready; o_en = row_if.enable_output; o_ov = row_if.out_valid;
        o_bd = row_if.block_done; o_fd = row_if.frame_done; o_busy = busy;
        o_row = int'(row_if.out_row); o_blk = int'(blk_idx);
        if (o_ov) obs_rows.push_back(o_row);

        tests += 9;
        if (row_if.in_ready !== e_ir) begin fails++;
            $display("FAIL in_ready t=%0t got %b exp %b", $time, row_if.in_ready, e_ir); end
        if (row_if.enable_output !== e_acc) begin fails++;
            $display("FAIL enable_output t=%0t got %b exp %b", $time, row_if.enable_output, e_acc); end
        if (row_if.out_valid !== m_ov) begin fails++;
            $display("FAIL out_valid t=%0t got %b exp %b", $time, row_if.out_valid, m_ov); end
        if (row_if.out_row !== ROW_W'(m_orow)) begin fails++;
            $display("FAIL out_row t=%0t got %0d exp %0d", $time, row_if.out_row, m_orow); end
        if (row_if.out_last_row !== m_olast) begin fails++;
            $display("FAIL out_last_row t=%0t got %b exp %b", $time, row_if.out_last_row, m_olast); end
        if (row_if.block_done !== m_olast) begin fails++;
            $display("FAIL block_done t=%0t got %b exp %b", $time, row_if.block_done, m_olast); end
        if (row_if.frame_done !== m_fd) begin fails++;
            $display("FAIL frame_done t=%0t got %b exp %b", $time, row_if.frame_done, m_fd); end
        if (blk_idx !== BW'(e_blk)) begin fails++;
            $display("FAIL blk_idx t=%0t got %0d exp %0d", $time, blk_idx, e_blk); end
        if (busy !== e_busy) begin fails++;
            $display("FAIL busy t=%0t got %b exp %b", $time, busy, e_busy); end
`ifdef QUANT_CTRL_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'(m_stall)) begin fails++;
            $display("FAIL stall_cnt t=%0t got %0d exp %0d", $time, stall_cnt, m_stall); end
`endif

        n_ov   = e_acc;
        n_row  = e_acc ? (m_rows % R) : 0;
        n_last = e_acc && ((m_rows % R) == R - 1);
        n_fd   = (e_acc && (m_rows + 1 == m_nblk * R)) ||
                 (!m_run && start && num_blocks == 0);
        if (m_run && row_if.in_valid && !row_if.out_ready && m_stall != 64'hFFFF_FFFF)
            m_stall++;
        if (!m_run) begin
            if (start && num_blocks != 0) begin
                m_run = 1; m_nblk = int'(num_blocks); m_rows = 0; m_stall = 0;
            end
        end else if (abort) begin
            m_run = 0; m_rows = 0;
        end else if (e_acc) begin
            m_rows++;
            if (m_rows == m_nblk * R) begin m_run = 0; m_rows = 0; end
        end
        @(posedge clk);
        m_ov = n_ov; m_orow = n_row; m_olast = n_last; m_fd = n_fd;
        #1;
    endtask

    task automatic run_until_rows(input int n, input string tag);
        int guard = 0;
        while (m_rows != n && guard < 300) begin tick(); guard++; end
        tests++;
        if (m_rows != n) begin fails++;
            $display("FAIL %s timeout got rows %0d exp %0d", tag, m_rows, n); end
    endtask

    task automatic drain();
        start = 0; abort = 0; row_if.in_valid = 0; row_if.out_ready = 1;
        if (m_run) begin abort = 1; tick(); abort = 0; end
        tick(); tick();
    endtask

    task automatic test_reset();
        row_if.in_valid = 0; row_if.out_ready = 0;
        #1;
        tests++;
        if ({row_if.in_ready, row_if.enable_output, row_if.out_valid, row_if.out_row,
             row_if.out_last_row, row_if.block_done, row_if.frame_done, busy} !== '0 ||
            blk_idx !== '0) begin fails++;
            $display("FAIL reset_outputs got ov=%b row=%0d fd=%b blk=%0d busy=%b exp all 0",
                     row_if.out_valid, row_if.out_row, row_if.frame_done, blk_idx, busy);
        end
`ifdef QUANT_CTRL_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'd0) begin fails++;
            $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
`endif
        @(posedge clk); @(posedge clk); #1;
        nrst = 1; model_reset();
        row_if.out_ready = 1;
        tick(); tick();
    endtask

    task automatic test_single_block();
        int en = 0, fd = 0, coinc = 0, first_en = -1, last_en = -1;
        obs_rows.delete();
        num_blocks = 1; start = 1; row_if.in_valid = 1; row_if.out_ready = 1;
        tick(); start = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (o_en) begin en++; if (first_en < 0) first_en = i; last_en = i; end
            if (o_fd) fd++;
            if (o_ov && o_bd && o_fd && o_row == R - 1) coinc++;
            if (i == 9) begin
                tests++;
                if (o_busy !== 1'b0) begin fails++;
                    $display("FAIL single_busy_after got %b exp 0", o_busy); end
            end
        end
        tests += 4;
        if (en != R || last_en - first_en != R - 1) begin fails++;
            $display("FAIL single_enable got %0d span %0d exp %0d", en, last_en - first_en, R); end
        if (obs_rows.size() != R) begin fails++;
            $display("FAIL single_row_count got %0d exp %0d", obs_rows.size(), R); end
        else for (int k = 0; k < R; k++) if (obs_rows[k] != k) begin fails++;
            $display("FAIL single_row_seq idx %0d got %0d exp %0d", k, obs_rows[k], k); break; end
        if (coinc != 1) begin fails++;
            $display("FAIL single_done_on_row7 got %0d exp 1", coinc); end
        if (fd != 1) begin fails++;
            $display("FAIL single_frame_done_count got %0d exp 1", fd); end
        drain();
    endtask

    task automatic test_multi_block();
        int nov = 0, fd_at = 0, fd_cnt = 0, max_blk = 0;
        int bd_at[$];
        num_blocks = 3; start = 1; row_if.in_valid = 0; row_if.out_ready = 1;
        tick(); start = 0;
        for (int i = 0; i < 80; i++) begin
            row_if.in_valid = (i % 2 == 0);
            tick();
            if (o_blk > max_blk) max_blk = o_blk;
            if (o_ov) begin
                nov++;
                if (o_bd) bd_at.push_back(nov);
                if (o_fd) begin fd_cnt++; fd_at = nov; end
            end
        end
        tests += 4;
        if (nov != 3 * R) begin fails++;
            $display("FAIL multi_out_valid_count got %0d exp %0d", nov, 3 * R); end
        if (bd_at.size() != 3 || bd_at[0] != 8 || bd_at[1] != 16 || bd_at[2] != 24) begin fails++;
            $display("FAIL multi_block_done_pos got %p exp 8,16,24", bd_at); end
        if (fd_cnt != 1 || fd_at != 24) begin fails++;
            $display("FAIL multi_frame_done got cnt %0d at %0d exp 1 at 24", fd_cnt, fd_at); end
        if (max_blk != 2) begin fails++;
            $display("FAIL multi_blk_idx_max got %0d exp 2", max_blk); end
        drain();
    endtask

    task automatic test_backpressure();
        obs_rows.delete();
        num_blocks = 1; start = 1; row_if.in_valid = 1; row_if.out_ready = 1;
        tick(); start = 0;
        run_until_rows(3, "bp_reach_row3");
        row_if.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (o_ir !== 1'b0 || o_en !== 1'b0) begin fails++;
                $display("FAIL bp_stalled cycle %0d got ir=%b en=%b exp 0", i, o_ir, o_en); end
        end
        row_if.out_ready = 1;
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if (obs_rows.size() != R) begin fails++;
            $display("FAIL bp_row_count got %0d exp %0d", obs_rows.size(), R); end
        else for (int k = 0; k < R; k++) if (obs_rows[k] != k) begin fails++;
            $display("FAIL bp_row_seq idx %0d got %0d exp %0d", k, obs_rows[k], k); break; end
`ifdef QUANT_CTRL_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'd5) begin fails++;
            $display("FAIL bp_stall_cnt got %0d exp 5", stall_cnt); end
`endif
        drain();
    endtask

    task automatic test_abort();
        int fd = 0;
        num_blocks = 4; start = 1; row_if.in_valid = 1; row_if.out_ready = 1;
        tick(); start = 0;
        run_until_rows(R + 5, "abort_reach_b1r5");
        abort = 1;
        tick();
        abort = 0;
        tests += 2;
        if (o_ir !== 1'b0 || o_en !== 1'b0) begin fails++;
            $display("FAIL abort_no_accept got ir=%b en=%b exp 0", o_ir, o_en); end
        if (o_ov !== 1'b1 || o_row != 4) begin fails++;
            $display("FAIL abort_prev_row_emerges got ov=%b row=%0d exp 1 row 4", o_ov, o_row); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_fd) fd++;
            if (i == 0) begin
                tests++;
                if (o_ir !== 1'b0 || o_ov !== 1'b0) begin fails++;
                    $display("FAIL abort_idle got ir=%b ov=%b exp 0", o_ir, o_ov); end
            end
        end
        tests++;
        if (fd != 0) begin fails++; $display("FAIL abort_frame_done got %0d exp 0", fd); end
        obs_rows.delete();
        start = 1; tick(); start = 0;
        tick();
        tests++;
        if (o_blk != 0 || o_en !== 1'b1) begin fails++;
            $display("FAIL abort_restart got blk=%0d en=%b exp 0 1", o_blk, o_en); end
        tick();
        tests++;
        if (obs_rows.size() < 1 || obs_rows[0] != 0) begin fails++;
            $display("FAIL abort_restart_row got size %0d exp first row 0", obs_rows.size()); end
        drain();
    endtask

    task automatic test_zero_blocks();
        int nov = 0;
        row_if.in_valid = 1; num_blocks = 0; start = 1;
        tick(); start = 0;
        tick();
        tests++;
        if (o_fd !== 1'b1 || o_ov !== 1'b0) begin fails++;
            $display("FAIL zero_frame_done got fd=%b ov=%b exp 1 0", o_fd, o_ov); end
        tick();
        if (o_ov) nov++;
        tests++;
        if (o_fd !== 1'b0) begin fails++; $display("FAIL zero_single_pulse got %b exp 0", o_fd); end
        for (int i = 0; i < 4; i++) begin tick(); if (o_ov) nov++; end
        tests++;
        if (nov != 0) begin fails++; $display("FAIL zero_out_valid got %0d exp 0", nov); end
        drain();
    endtask

    task automatic test_start_in_run();
        int fd = 0;
        obs_rows.delete();
        num_blocks = 2; start = 1; row_if.in_valid = 1; row_if.out_ready = 1;
        tick(); start = 0;
        run_until_rows(5, "sir_reach_row5");
        num_blocks = 7; start = 1; tick(); start = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (o_fd) fd++; end
        tests += 2;
        if (obs_rows.size() != 2 * R) begin fails++;
            $display("FAIL start_in_run_rows got %0d exp %0d", obs_rows.size(), 2 * R); end
        if (fd != 1) begin fails++; $display("FAIL start_in_run_fd got %0d exp 1", fd); end
        drain();
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        num_blocks = 1; start = 1; row_if.in_valid = 1; row_if.out_ready = 1;
        tick(); start = 0;
        while (!m_fd && guard < 50) begin tick(); guard++; end
        start = 1;
        tick(); start = 0;
        tests++;
        if (o_fd !== 1'b1) begin fails++;
            $display("FAIL b2b_start_on_fd got fd=%b exp 1", o_fd); end
        tick();
        tests++;
        if (o_en !== 1'b1 || o_blk != 0) begin fails++;
            $display("FAIL b2b_accept got en=%b blk=%0d exp 1 0", o_en, o_blk); end
        for (int i = 0; i < 10; i++) tick();
        drain();
    endtask

    task automatic test_async_reset();
        num_blocks = 2; start = 1; row_if.in_valid = 1; row_if.out_ready = 1;
        tick(); start = 0;
        run_until_rows(4, "ar_reach_row4");
        #2 nrst = 0;
        #1;
        tests++;
        if ({row_if.in_ready, row_if.enable_output, row_if.out_valid, row_if.out_row,
             row_if.out_last_row, row_if.block_done, row_if.frame_done, busy} !== '0 ||
            blk_idx !== '0) begin fails++;
            $display("FAIL async_reset_outputs got ov=%b row=%0d en=%b busy=%b exp all 0",
                     row_if.out_valid, row_if.out_row, row_if.enable_output, busy);
        end
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        nrst = 1;
        obs_rows.delete();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (obs_rows.size() < 2 || obs_rows[0] != 0 || obs_rows[1] != 1) begin fails++;
            $display("FAIL async_reset_restart got size %0d exp rows 0,1", obs_rows.size()); end
        drain();
    endtask

    task automatic test_random();
        int frames = 0;
        for (int i = 0; i < 3000; i++) begin
            row_if.in_valid  = ($urandom_range(0, 3) != 0);
            row_if.out_ready = ($urandom_range(0, 3) != 0);
            abort            = ($urandom_range(0, 63) == 0);
            start            = ($urandom_range(0, 7) == 0);
            num_blocks       = BW'($urandom_range(0, 3));
            tick();
            if (o_fd && o_ov) frames++;
        end
        tests++;
        if (frames == 0) begin fails++; $display("FAIL random_frames got 0 exp >0"); end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_block();
        test_multi_block();
        test_backpressure();
        test_abort();
        test_zero_blocks();
        test_start_in_run();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_quant_ctrl

// File: doc/quant_ctrl.md
Name: quant_ctrl

Overview:
- Sequencer for the 8-lane quantizer stage (9-bit in, 8-bit rounded out, 1-cycle registered, zeroes outputs when enable low).
- Accepts rows from the transform stage via valid/ready and drives the quantizer's enable_output.
- Counts rows per block and blocks per frame; emits row index, last-row, block-done and frame-done markers aligned to the quantizer's registered outputs.

Parameters:
ROWS_PER_BLOCK, 8, rows per block; must be ≥2
BLK_CNT_W, 16, width of block count and index
ROW_W, $clog2(ROWS_PER_BLOCK), row index width (derived)

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
start  input  1  frame start pulse; sampled only in IDLE
abort  input  1  synchronous frame abort
num_blocks  input  BLK_CNT_W  blocks in frame; latched on accepted start
in_valid  input  1  upstream row valid
in_ready  output  1  upstream row accept
out_ready  input  1  downstream credit: high at cycle t guarantees acceptance of an out_valid at t+1
enable_output  output  1  drives quantizer enable
out_valid  output  1  quantizer output row valid
out_row  output  ROW_W  row index of current quantizer output
out_last_row  output  1  out_row == ROWS_PER_BLOCK-1
block_done  output  1  last row of a block on output
frame_done  output  1  last row of frame on output
blk_idx  output  BLK_CNT_W  index of block currently being accepted
busy  output  1  state==RUN or out_valid

Behaviour:
- Reset: all outputs 0; state IDLE; row_cnt, blk_idx and latched num_blocks 0.
- States: IDLE, RUN.
- IDLE → RUN: start && num_blocks != 0 latches num_blocks and clears row_cnt and blk_idx.
- start with num_blocks == 0: frame_done pulses the next cycle, out_valid stays 0, state stays IDLE.
- in_ready = (state==RUN) && out_ready && !abort, combinational.
- accept = in_valid && in_ready.
- enable_output = accept, same cycle as the row data at the quantizer inputs.
- On accept: row_cnt increments. At ROWS_PER_BLOCK-1 it wraps to 0 and blk_idx increments.
- Last row of last block (blk_idx == num_blocks-1): RUN → IDLE next cycle; blk_idx clears to 0.
- 1-cycle registered markers, aligned with quantizer outputs:
  - out_valid <= accept
  - out_row <= row_cnt
  - out_last_row <= accept && row_cnt == last row
  - block_done <= same condition as out_last_row
  - frame_done <= block_done condition && last block
- When out_valid is 0: out_row, out_last_row, block_done and frame_done are 0.
- start while in RUN is ignored. A new start is accepted in the IDLE cycle in which the final frame_done is asserted.
- abort in RUN: in_ready forced low that cycle; next cycle IDLE with row_cnt and blk_idx cleared and no frame_done. A row accepted the previous cycle still emerges with out_valid.
- abort in IDLE: no effect. abort and start in the same cycle in IDLE: start wins.
- in_valid with out_ready low: no accept, counters hold, enable_output 0.
- Asynchronous nrst mid-frame: immediate return to reset values; the partial frame is dropped.
- Counters do not saturate. blk_idx wrap is impossible because num_blocks is bounded by BLK_CNT_W.

Optional Feature:
QUANT_CTRL_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0].
  - Counts cycles where state==RUN && in_valid && !out_ready.
  - Clears on accepted start and on reset; saturates at all-ones.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package quant_pkg holds:
  - ROWS_PER_BLOCK default
  - lane count (8), input width (9), output width (8)
  - state encoding constants IDLE/RUN
- No sub-module: the FSM, counters and marker pipeline stay in one module.

Test Plan:
- Reset, then start with num_blocks=1 and in_valid held high, out_ready=1 → enable_output high for 8 consecutive cycles; out_row 0..7 one cycle later; block_done and frame_done together on out_row=7; busy low the following cycle.
- num_blocks=3 with in_valid toggling every other cycle → exactly 24 out_valid pulses; block_done on the 8th, 16th and 24th; blk_idx 0→1→2; frame_done only on the 24th.
- out_ready low for 5 cycles mid-block at row 3 → in_ready and enable_output 0 for those cycles; row 3 accepted after out_ready returns; no row skipped or duplicated.
- abort asserted together with in_valid at row 5 of block 1 (num_blocks=4) → no accept that cycle; state IDLE next cycle; no frame_done; next start restarts at blk_idx=0, row 0.
- start with num_blocks=0 → single frame_done pulse the next cycle, out_valid never set. Separately, start during RUN → ignored, counts unaffected.
- nrst asserted asynchronously at row 4 → all outputs 0 immediately; after release and start, out_row sequence restarts at 0. With QUANT_CTRL_STALL_CNT_EN defined, the third scenario reads stall_cnt=5.
